event_capture_ctrl: RTL
=======================

EVENT_CAPTURE_CTRL -- requirements
Module: event_capture_ctrl

Interface
REQ-001 SHALL have CLK, input, 1: fast acquisition clock; all logic on its rising edge.
REQ-002 SHALL have RESET, input, 1: synchronous, active-high reset.
REQ-003 SHALL have TRIGGER_ACTIVE, input, 1: trigger handler output, CLK-synchronous.
REQ-004 SHALL have READ_MODE, input, 1: high freezes capture and enables readout.
REQ-005 SHALL have CLEAR, input, 1: single-cycle pulse that empties the buffer.
REQ-006 SHALL have TOT_SHORT and TOT_LONG, input, 16 each: TOT values sampled at capture.
REQ-007 SHALL have RD_REQ, input, 1: pops one 16-bit word; level-sampled each cycle.
REQ-008 SHALL have RD_VALID, output, 1: one-cycle strobe qualifying RD_DATA.
REQ-009 SHALL have RD_DATA, output, 16: popped word.
REQ-010 SHALL have EVENT_COUNT (7), DROP_COUNT (16), FULL (1) and EMPTY (1) as outputs: buffer status.

Function
REQ-011 SHALL keep a free-running 16-bit TIMESTAMP counter, +1 per CLK, wrapping 0xFFFF->0.
REQ-012 SHALL detect the trigger edge as TRIGGER_ACTIVE=1 while its previous-cycle registered value was 0.
REQ-013 SHALL, on an edge in state IDLE with READ_MODE=0 and FULL=0, latch EVENT_INDEX, TIMESTAMP, TOT_SHORT and TOT_LONG in that same cycle, then go to W0.
REQ-014 SHALL store each record as 4 words, one per cycle, in states W0..W3: W0=EVENT_INDEX, W1=TIMESTAMP, W2=TOT_SHORT, W3=TOT_LONG; W3 then returns to IDLE.
REQ-015 SHALL, at the W3 write, increment EVENT_INDEX (16-bit, wraps) and EVENT_COUNT.
REQ-016 SHALL use a 256x16 ring buffer (64 records), with an 8-bit write pointer and an 8-bit read pointer that both wrap at 255->0.
REQ-017 SHALL drop an edge that arrives while FULL=1 or while the FSM is not IDLE, and increment DROP_COUNT; DROP_COUNT saturates at 0xFFFF.
REQ-018 SHALL ignore edges while READ_MODE=1, with no capture and no drop count.
REQ-019 SHALL complete an in-progress record when READ_MODE rises mid-record; readout is held off until the FSM returns to IDLE.
REQ-020 SHALL accept RD_REQ only when READ_MODE=1, the FSM is IDLE and the buffer holds at least one word (EMPTY=0); otherwise RD_REQ is ignored and RD_VALID stays 0.
REQ-021 SHALL, for each accepted RD_REQ, assert RD_VALID with the word at the read pointer exactly 2 cycles later (address register plus registered RAM output), and advance the read pointer by 1.
REQ-022 SHALL accept back-to-back RD_REQ; each cycle then yields one word, in order.
REQ-023 SHALL decrement EVENT_COUNT when the 4th word of a record is accepted; a partially read record still counts.
REQ-024 SHALL drive FULL=(EVENT_COUNT==64) and EMPTY=(read pointer==write pointer).
REQ-025 SHALL, on CLEAR, zero both pointers, EVENT_COUNT and DROP_COUNT, return the FSM to IDLE, and discard in-flight reads (no RD_VALID); TIMESTAMP and EVENT_INDEX are not cleared.
REQ-026 SHALL let CLEAR win over a trigger edge or RD_REQ in the same cycle.

Reset
REQ-027 SHALL, on RESET, set TIMESTAMP=0, EVENT_INDEX=0, pointers=0, EVENT_COUNT=0, DROP_COUNT=0, FSM=IDLE, RD_VALID=0, RD_DATA=0, FULL=0, EMPTY=1, and the edge register to 0.
REQ-028 SHALL, on RESET mid-record or mid-read, abandon the record with no partial count and emit no further RD_VALID.

Verification
REQ-029 SHALL pass: reset; set TOT_SHORT=0x0012 and TOT_LONG=0x0034; pulse TRIGGER_ACTIVE at TIMESTAMP=0x0100; set READ_MODE=1; issue 4 RD_REQ -> RD_DATA 0x0000, 0x0100, 0x0012, 0x0034, with EVENT_COUNT going 1->0 and EMPTY=1.
REQ-030 SHALL pass: 65 spaced triggers -> EVENT_COUNT=64, FULL=1, DROP_COUNT=1; reading one full record -> FULL=0.
REQ-031 SHALL pass: a second edge 2 cycles after the first -> one record stored, DROP_COUNT=1.
REQ-032 SHALL pass: a trigger while READ_MODE=1 -> EVENT_COUNT and DROP_COUNT unchanged.
REQ-033 SHALL pass: fill 64 records, read all, then capture 1 more -> pointers wrap, the new record is read correctly, and EVENT_INDEX=0x0040.
REQ-034 SHALL pass: CLEAR in the same cycle as a trigger edge and as RD_REQ -> EMPTY=1, EVENT_COUNT=0, and no RD_VALID.

Source files
------------

// File: rtl/event_capture_ctrl.sv
// rtl/event_capture_ctrl.sv - trigger-edge event capture into a 256x16 ring buffer with frozen readout
module event_capture_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TRIGGER_ACTIVE,
    input  logic        READ_MODE,
    input  logic        CLEAR,
    input  logic [15:0] TOT_SHORT,
    input  logic [15:0] TOT_LONG,
    input  logic        RD_REQ,
    output logic        RD_VALID,
    output logic [15:0] RD_DATA,
    output logic [6:0]  EVENT_COUNT,
    output logic [15:0] DROP_COUNT,
    output logic        FULL,
    output logic        EMPTY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2,
        S_W3
    } state_t;

    state_t state, state_next;

    logic [15:0] timestamp;
    logic [15:0] event_index;
    logic [15:0] lat_index, lat_ts, lat_tot_short, lat_tot_long;
    logic        trig_q;
    logic [7:0]  wr_ptr, rd_ptr, rd_addr_q;
    logic        rd_pend;
    logic [15:0] mem [0:255];

    logic        trig_edge, capture, drop, rd_accept, wr_en, rec_done;
    logic [15:0] wr_word;

    assign trig_edge = TRIGGER_ACTIVE & ~trig_q;
    assign capture   = trig_edge & ~READ_MODE & ~FULL & (state == S_IDLE) & ~CLEAR;
    assign drop      = trig_edge & ~READ_MODE & (FULL | (state != S_IDLE)) & ~CLEAR;
    assign rd_accept = RD_REQ & READ_MODE & (state == S_IDLE) & ~EMPTY & ~CLEAR;
    assign rec_done  = wr_en & (state == S_W3);

    assign FULL  = (EVENT_COUNT == 7'd64);
    // The pointers also meet when all 64 records are stored; that case is full, not empty.
    assign EMPTY = (rd_ptr == wr_ptr) & ~FULL;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_word    = lat_index;
        case (state)
            S_IDLE: if (capture) state_next = S_W0;
            S_W0: begin
                wr_en      = 1'b1;
                wr_word    = lat_index;
                state_next = S_W1;
            end
            S_W1: begin
                wr_en      = 1'b1;
                wr_word    = lat_ts;
                state_next = S_W2;
            end
            S_W2: begin
                wr_en      = 1'b1;
                wr_word    = lat_tot_short;
                state_next = S_W3;
            end
            S_W3: begin
                wr_en      = 1'b1;
                wr_word    = lat_tot_long;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (CLEAR) begin
            state_next = S_IDLE;
            wr_en      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            timestamp     <= 16'd0;
            event_index   <= 16'd0;
            lat_index     <= 16'd0;
            lat_ts        <= 16'd0;
            lat_tot_short <= 16'd0;
            lat_tot_long  <= 16'd0;
            trig_q        <= 1'b0;
            wr_ptr        <= 8'd0;
            rd_ptr        <= 8'd0;
            rd_addr_q     <= 8'd0;
            rd_pend       <= 1'b0;
            RD_VALID      <= 1'b0;
            RD_DATA       <= 16'd0;
            EVENT_COUNT   <= 7'd0;
            DROP_COUNT    <= 16'd0;
        end else begin
            timestamp <= timestamp + 16'd1;
            trig_q    <= TRIGGER_ACTIVE;

            if (capture) begin
                lat_index     <= event_index;
                lat_ts        <= timestamp;
                lat_tot_short <= TOT_SHORT;
                lat_tot_long  <= TOT_LONG;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (rec_done) begin
                event_index <= event_index + 16'd1;
            end

            // Two-stage read: address register, then registered RAM output.
            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_addr_q <= rd_ptr;
                rd_ptr    <= rd_ptr + 8'd1;
            end
            RD_VALID <= rd_pend;
            if (rd_pend) begin
                RD_DATA <= mem[rd_addr_q];
            end

            // Writes happen only outside IDLE and reads only in IDLE, so these never coincide.
            if (rec_done) begin
                EVENT_COUNT <= EVENT_COUNT + 7'd1;
            end else if (rd_accept && (rd_ptr[1:0] == 2'd3)) begin
                EVENT_COUNT <= EVENT_COUNT - 7'd1;
            end

            if (drop && (DROP_COUNT != 16'hFFFF)) begin
                DROP_COUNT <= DROP_COUNT + 16'd1;
            end

            if (CLEAR) begin
                wr_ptr      <= 8'd0;
                rd_ptr      <= 8'd0;
                rd_pend     <= 1'b0;
                RD_VALID    <= 1'b0;
                EVENT_COUNT <= 7'd0;
                DROP_COUNT  <= 16'd0;
            end
        end
    end

endmodule
